// File: rtl/cpu_bus_responder_pkg.sv
// -----------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the CPU bus responder slice:
//   - default bus widths and the open-bus read value
//   - T-phase constants T0..T3 of a machine cycle
//   - responder FSM state codes (IDLE, READ, WRITE)
//   - default HRAM window that stays reachable while OAM DMA owns the bus
// -----------------------------------------------------------------------------
package bus_pkg;

    localparam int BUS_ADDR_W = 16;
    localparam int BUS_DATA_W = 8;

    localparam logic [BUS_DATA_W-1:0] BUS_OPEN_BUS = 8'hFF;
    localparam logic [BUS_ADDR_W-1:0] BUS_HRAM_LO  = 16'hFF80;
    localparam logic [BUS_ADDR_W-1:0] BUS_HRAM_HI  = 16'hFFFE;

    // T-phases of one machine cycle; one phase per clk.
    localparam logic [1:0] T0 = 2'd0;
    localparam logic [1:0] T1 = 2'd1;
    localparam logic [1:0] T2 = 2'd2;
    localparam logic [1:0] T3 = 2'd3;

    // Responder FSM state codes, kept as plain constants for legacy tools.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;

endpackage

// File: rtl/cpu_bus_responder_if.sv
// -----------------------------------------------------------------------------
// cpu_bus_if
// Bundles the core-side request/data pins and the memory-port strobes that the
// responder sits between.
//   master : core + memory fabric side (drives requests, read data, ack, DMA)
//   slave  : the responder (drives CPU_DIN, phase, memory strobes, pulses)
// Signals:
//   cpu_rd, cpu_wr, cpu_addr, cpu_dout   core request, sampled by the responder
//   cpu_din, din_valid                   read data back to the core latch
//   phase                                current T-phase 0..3
//   mem_addr, mem_rd, mem_wr, mem_wdata  memory-port access
//   mem_rdata, mem_ack                   memory read return
//   dma_active                           OAM DMA in progress
//   bus_timeout, bus_conflict            one-clk status pulses
// -----------------------------------------------------------------------------
interface cpu_bus_if
    import bus_pkg::*;
#(
    parameter int ADDR_W = BUS_ADDR_W,
    parameter int DATA_W = BUS_DATA_W
);

    logic              cpu_rd;
    logic              cpu_wr;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_dout;
    logic [DATA_W-1:0] cpu_din;
    logic              din_valid;
    logic [1:0]        phase;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
    logic              dma_active;
    logic              bus_timeout;
    logic              bus_conflict;

    modport master (
        output cpu_rd, cpu_wr, cpu_addr, cpu_dout, mem_rdata, mem_ack, dma_active,
        input  cpu_din, din_valid, phase, mem_addr, mem_rd, mem_wr, mem_wdata,
               bus_timeout, bus_conflict
    );

    modport slave (
        input  cpu_rd, cpu_wr, cpu_addr, cpu_dout, mem_rdata, mem_ack, dma_active,
        output cpu_din, din_valid, phase, mem_addr, mem_rd, mem_wr, mem_wdata,
               bus_timeout, bus_conflict
    );

endinterface

// File: rtl/cpu_bus_responder_phase_counter.sv
// -----------------------------------------------------------------------------
// bus_phase_counter
// Free-running 2-bit T-phase counter: 0,1,2,3,0,... with no gap at the wrap.
// Ports:
//   clk    in   single clock, one T-phase per clk
//   reset  in   synchronous, active-high; forces phase T0
//   phase  out  current T-phase
// -----------------------------------------------------------------------------
module bus_phase_counter
    import bus_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    output logic [1:0] phase
);

    // NOTE: registers use non-blocking assignment so every flop samples the
    // pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase <= T0;
        end else begin
            phase <= phase + 2'd1;   // natural 2-bit wrap 3 -> 0
        end
    end

endmodule

// File: rtl/cpu_bus_responder.sv
// -----------------------------------------------------------------------------
// cpu_bus_responder
// ASIC-side end of the CPU data-latch interface. Each machine cycle is four
// T-phases; the request is sampled once in T0, one memory-port access is
// issued, read data is presented to the core latch during T3 and then kept
// (bus keeper) until the next completed read.
//
// Ports:
//   clk    in   single clock, one T-phase per clk
//   reset  in   synchronous, active-high
//   bus    cpu_bus_if.slave (core request/data, memory port, status pulses)
//
// Configuration:
//   BUS_DMA_LOCK_EN  when defined, an access sampled in T0 with dma_active
//                    high and an address outside HRAM_LO..HRAM_HI gets no
//                    memory strobe; reads return OPEN_BUS without a timeout,
//                    writes are dropped. Undefined: dma_active is ignored.
// -----------------------------------------------------------------------------
module cpu_bus_responder
    import bus_pkg::*;
#(
    parameter int                ADDR_W   = BUS_ADDR_W,
    parameter int                DATA_W   = BUS_DATA_W,
    parameter logic [DATA_W-1:0] OPEN_BUS = BUS_OPEN_BUS,
    parameter logic [ADDR_W-1:0] HRAM_LO  = BUS_HRAM_LO,
    parameter logic [ADDR_W-1:0] HRAM_HI  = BUS_HRAM_HI
)(
    input  logic     clk,
    input  logic     reset,
    cpu_bus_if.slave bus
);

    logic [1:0]        phase;
    logic [1:0]        state_q;
    logic              mem_rd_q;
    logic              mem_wr_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] cpu_din_q;
    logic              din_valid_q;
    logic              timeout_q;
    logic              conflict_q;
    logic              rd_acked_q;    // first ack of this read already taken
    logic              rd_blocked_q;  // read suppressed by the DMA lock
    logic [DATA_W-1:0] rdata_q;       // read data captured on the first ack

    logic in_hram;
    logic lock_hit;
    logic ack_hit;

    bus_phase_counter u_phase (
        .clk   (clk),
        .reset (reset),
        .phase (phase)
    );

    assign in_hram = (bus.cpu_addr >= HRAM_LO) && (bus.cpu_addr <= HRAM_HI);

`ifdef BUS_DMA_LOCK_EN
    assign lock_hit = bus.dma_active && !in_hram;
`else
    assign lock_hit = 1'b0;
    logic unused_lock;
    assign unused_lock = bus.dma_active ^ in_hram;
`endif

    // mem_rd_q is only ever high in READ phases 1-2, so an ack seen anywhere
    // else falls out of this term and is ignored.
    assign ack_hit = mem_rd_q && bus.mem_ack;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            mem_rd_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            cpu_din_q    <= OPEN_BUS;
            din_valid_q  <= 1'b0;
            timeout_q    <= 1'b0;
            conflict_q   <= 1'b0;
            rd_acked_q   <= 1'b0;
            rd_blocked_q <= 1'b0;
            rdata_q      <= OPEN_BUS;
        end else begin
            // Status outputs are single-clk pulses unless re-asserted below.
            timeout_q  <= 1'b0;
            conflict_q <= 1'b0;

            case (phase)
                T0: begin
                    mem_addr_q   <= bus.cpu_addr;
                    rd_acked_q   <= 1'b0;
                    rd_blocked_q <= 1'b0;
                    if (bus.cpu_rd && bus.cpu_wr) begin
                        state_q    <= ST_IDLE;
                        conflict_q <= 1'b1;
                    end else if (bus.cpu_rd) begin
                        // A locked read still runs the cycle so the core
                        // gets OPEN_BUS in T3, but never strobes memory.
                        state_q      <= ST_READ;
                        rd_blocked_q <= lock_hit;
                        mem_rd_q     <= !lock_hit;
                    end else if (bus.cpu_wr && !lock_hit) begin
                        state_q <= ST_WRITE;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end

                T1: begin
                    if (ack_hit) begin
                        rdata_q    <= bus.mem_rdata;
                        rd_acked_q <= 1'b1;
                        mem_rd_q   <= 1'b0;
                    end
                    if (state_q == ST_WRITE) begin
                        mem_wdata_q <= bus.cpu_dout;
                        mem_wr_q    <= 1'b1;
                    end
                end

                T2: begin
                    mem_rd_q <= 1'b0;
                    mem_wr_q <= 1'b0;
                    if (state_q == ST_READ) begin
                        din_valid_q <= 1'b1;
                        if (ack_hit) begin
                            rdata_q   <= bus.mem_rdata;
                            cpu_din_q <= bus.mem_rdata;
                        end else if (rd_acked_q) begin
                            cpu_din_q <= rdata_q;
                        end else begin
                            rdata_q   <= OPEN_BUS;
                            cpu_din_q <= OPEN_BUS;
                            timeout_q <= !rd_blocked_q;
                        end
                    end
                end

                default: begin   // T3: close the machine cycle
                    din_valid_q <= 1'b0;
                    mem_rd_q    <= 1'b0;
                    mem_wr_q    <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.phase        = phase;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_rd       = mem_rd_q;
    assign bus.mem_wr       = mem_wr_q;
    assign bus.mem_wdata    = mem_wdata_q;
    assign bus.cpu_din      = cpu_din_q;
    assign bus.din_valid    = din_valid_q;
    assign bus.bus_timeout  = timeout_q;
    assign bus.bus_conflict = conflict_q;

endmodule

// File: tb/tb_cpu_bus_responder.sv
// -----------------------------------------------------------------------------
// tb_cpu_bus_responder
// Self-checking bench for cpu_bus_responder. Expected read data is pushed to a
// queue when a read is issued and popped whenever the responder raises
// din_valid. Strobe timing is checked per phase inside each scenario task.
// Build with +define+BUS_DMA_LOCK_EN to exercise the DMA lock.
// -----------------------------------------------------------------------------
module tb_cpu_bus_responder;
    import bus_pkg::*;

    logic clk = 1'b0;
    logic reset;

    cpu_bus_if bus ();

    cpu_bus_responder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] exp_q [$];
    logic [7:0] last_din;

    // Per-phase observations of the most recent machine cycle.
    logic       obs_rd  [4];
    logic       obs_wr  [4];
    logic       obs_to  [4];
    logic       obs_cf  [4];
    logic       obs_dv  [4];
    logic [7:0] obs_din [4];
    logic [15:0] obs_addr;
    logic [7:0]  obs_wdata;

    task automatic drive_idle();
        bus.cpu_rd     = 1'b0;
        bus.cpu_wr     = 1'b0;
        bus.cpu_addr   = 16'h0000;
        bus.cpu_dout   = 8'h00;
        bus.mem_rdata  = 8'h00;
        bus.mem_ack    = 1'b0;
        bus.dma_active = 1'b0;
    endtask

    // Records outputs for phase p and pops the scoreboard on din_valid.
    task automatic sample(input int p);
        logic [7:0] e;
        obs_rd[p]  = bus.mem_rd;
        obs_wr[p]  = bus.mem_wr;
        obs_to[p]  = bus.bus_timeout;
        obs_cf[p]  = bus.bus_conflict;
        obs_dv[p]  = bus.din_valid;
        obs_din[p] = bus.cpu_din;
        obs_addr   = bus.mem_addr;
        obs_wdata  = bus.mem_wdata;
        if (bus.din_valid === 1'b1) begin
            n_assert++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: din_valid with nothing expected, cpu_din=%h", bus.cpu_din);
            end else begin
                e = exp_q.pop_front();
                if (bus.cpu_din !== e) begin
                    n_fail++;
                    $display("FAIL sb_cpu_din: got %h expected %h", bus.cpu_din, e);
                end
            end
        end
    endtask

    task automatic wait_phase0();
        int n = 0;
        @(negedge clk);
        while (bus.phase !== T0 && n < 8) begin
            @(negedge clk);
            n++;
        end
        n_assert++;
        if (bus.phase !== T0) begin
            n_fail++;
            $display("FAIL phase_sync: phase=%0d expected 0 within 8 clocks", bus.phase);
        end
    endtask

    // One machine cycle. Request pins are inverted after T0 and write data
    // after T1 so any sampling outside the defined phase shows up.
    // ack_ph selects the phase in which mem_ack is high (4 = never).
    task automatic run_cycle(input logic rd, input logic wr, input logic [15:0] addr,
                             input logic [7:0] dout, input int ack_ph,
                             input logic [7:0] ack_data, input logic dma);
        wait_phase0();
        sample(0);
        bus.cpu_rd     = rd;
        bus.cpu_wr     = wr;
        bus.cpu_addr   = addr;
        bus.cpu_dout   = dout;
        bus.dma_active = dma;
        bus.mem_ack    = (ack_ph == 0);
        bus.mem_rdata  = (ack_ph == 0) ? ack_data : 8'hE7;
        for (int p = 1; p < 4; p++) begin
            @(negedge clk);
            sample(p);
            bus.cpu_rd     = ~rd;
            bus.cpu_wr     = ~wr;
            bus.cpu_addr   = ~addr;
            bus.dma_active = ~dma;
            if (p == 2) bus.cpu_dout = ~dout;
            bus.mem_ack    = (ack_ph == p);
            bus.mem_rdata  = (ack_ph == p) ? ack_data : 8'hE7;
        end
    endtask

    task automatic expect_read(input logic [7:0] v);
        exp_q.push_back(v);
        last_din = v;
    endtask

    task automatic test_reset();
        drive_idle();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_assert++;
        if (bus.phase !== T0) begin n_fail++; $display("FAIL reset_phase: got %0d expected 0", bus.phase); end
        n_assert++;
        if (bus.mem_rd !== 1'b0 || bus.mem_wr !== 1'b0) begin
            n_fail++; $display("FAIL reset_strobes: rd=%b wr=%b expected 0 0", bus.mem_rd, bus.mem_wr);
        end
        n_assert++;
        if (bus.mem_addr !== 16'h0000 || bus.mem_wdata !== 8'h00) begin
            n_fail++; $display("FAIL reset_latches: addr=%h wdata=%h expected 0000 00", bus.mem_addr, bus.mem_wdata);
        end
        n_assert++;
        if (bus.cpu_din !== 8'hFF || bus.din_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_din: din=%h valid=%b expected ff 0", bus.cpu_din, bus.din_valid);
        end
        n_assert++;
        if (bus.bus_timeout !== 1'b0 || bus.bus_conflict !== 1'b0) begin
            n_fail++; $display("FAIL reset_pulses: to=%b cf=%b expected 0 0", bus.bus_timeout, bus.bus_conflict);
        end
        reset = 1'b0;
        last_din = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_assert++;
            if (bus.phase !== 2'(i + 1)) begin
                n_fail++; $display("FAIL phase_run[%0d]: got %0d expected %0d", i, bus.phase, (i + 1) % 4);
            end
        end
    endtask

    task automatic test_read_ack();
        logic [7:0] prev = last_din;
        expect_read(8'h5A);
        run_cycle(1'b1, 1'b0, 16'hC000, 8'h00, 1, 8'h5A, 1'b0);
        n_assert++;
        if ({obs_rd[1], obs_rd[2], obs_rd[3]} !== 3'b100) begin
            n_fail++; $display("FAIL read_ack_mem_rd: p1..3=%b%b%b expected 100", obs_rd[1], obs_rd[2], obs_rd[3]);
        end
        n_assert++;
        if (obs_addr !== 16'hC000) begin n_fail++; $display("FAIL read_ack_addr: got %h expected c000", obs_addr); end
        n_assert++;
        if ({obs_dv[1], obs_dv[2], obs_dv[3]} !== 3'b001) begin
            n_fail++; $display("FAIL read_ack_valid: p1..3=%b%b%b expected 001", obs_dv[1], obs_dv[2], obs_dv[3]);
        end
        n_assert++;
        if (obs_din[2] !== prev) begin n_fail++; $display("FAIL read_ack_hold: p2 din=%h expected %h", obs_din[2], prev); end
        n_assert++;
        if (obs_to[3] !== 1'b0) begin n_fail++; $display("FAIL read_ack_timeout: got %b expected 0", obs_to[3]); end
    endtask

    task automatic test_write();
        run_cycle(1'b0, 1'b1, 16'h8000, 8'h3C, 4, 8'h00, 1'b0);
        n_assert++;
        if ({obs_wr[1], obs_wr[2], obs_wr[3]} !== 3'b010) begin
            n_fail++; $display("FAIL write_mem_wr: p1..3=%b%b%b expected 010", obs_wr[1], obs_wr[2], obs_wr[3]);
        end
        n_assert++;
        if (obs_wdata !== 8'h3C || obs_addr !== 16'h8000) begin
            n_fail++; $display("FAIL write_latch: wdata=%h addr=%h expected 3c 8000", obs_wdata, obs_addr);
        end
        n_assert++;
        if ((obs_rd[1] | obs_rd[2] | obs_rd[3]) !== 1'b0) begin n_fail++; $display("FAIL write_no_rd: mem_rd seen, expected none"); end
        n_assert++;
        if (obs_din[3] !== last_din || obs_dv[3] !== 1'b0) begin
            n_fail++; $display("FAIL write_din: din=%h valid=%b expected %h 0", obs_din[3], obs_dv[3], last_din);
        end
    endtask

    task automatic test_read_timeout();
        expect_read(8'hFF);
        run_cycle(1'b1, 1'b0, 16'hC001, 8'h00, 4, 8'h00, 1'b0);
        n_assert++;
        if ({obs_rd[1], obs_rd[2], obs_rd[3]} !== 3'b110) begin
            n_fail++; $display("FAIL timeout_mem_rd: p1..3=%b%b%b expected 110", obs_rd[1], obs_rd[2], obs_rd[3]);
        end
        n_assert++;
        if ({obs_to[1], obs_to[2], obs_to[3]} !== 3'b001) begin
            n_fail++; $display("FAIL timeout_pulse: p1..3=%b%b%b expected 001", obs_to[1], obs_to[2], obs_to[3]);
        end
        n_assert++;
        if (obs_dv[3] !== 1'b1) begin n_fail++; $display("FAIL timeout_valid: got %b expected 1", obs_dv[3]); end
    endtask

    task automatic test_ack_timing();
        // Ack in phase 2: read completes, strobe held through phase 2.
        expect_read(8'h77);
        run_cycle(1'b1, 1'b0, 16'hC010, 8'h00, 2, 8'h77, 1'b0);
        n_assert++;
        if ({obs_rd[1], obs_rd[2], obs_to[3]} !== 3'b110) begin
            n_fail++; $display("FAIL late_ack: rd1=%b rd2=%b to=%b expected 1 1 0", obs_rd[1], obs_rd[2], obs_to[3]);
        end
        // Ack only in phase 3 or phase 0 is outside the window: timeout.
        expect_read(8'hFF);
        run_cycle(1'b1, 1'b0, 16'hC011, 8'h00, 3, 8'h99, 1'b0);
        n_assert++;
        if (obs_to[3] !== 1'b1) begin n_fail++; $display("FAIL ack_p3_ignored: timeout=%b expected 1", obs_to[3]); end
        expect_read(8'hFF);
        run_cycle(1'b1, 1'b0, 16'hC012, 8'h00, 0, 8'h66, 1'b0);
        n_assert++;
        if (obs_to[3] !== 1'b1) begin n_fail++; $display("FAIL ack_p0_ignored: timeout=%b expected 1", obs_to[3]); end
    endtask

    task automatic test_conflict();
        expect_read(8'h21);
        run_cycle(1'b1, 1'b0, 16'hC020, 8'h00, 1, 8'h21, 1'b0);
        run_cycle(1'b1, 1'b1, 16'hC021, 8'h55, 1, 8'hAA, 1'b0);
        n_assert++;
        if ({obs_cf[1], obs_cf[2], obs_cf[3]} !== 3'b100) begin
            n_fail++; $display("FAIL conflict_pulse: p1..3=%b%b%b expected 100", obs_cf[1], obs_cf[2], obs_cf[3]);
        end
        n_assert++;
        if ((obs_rd[1] | obs_rd[2] | obs_rd[3] | obs_wr[1] | obs_wr[2] | obs_wr[3]) !== 1'b0) begin
            n_fail++; $display("FAIL conflict_strobes: memory strobe seen, expected none");
        end
        n_assert++;
        if (obs_din[3] !== 8'h21 || obs_dv[3] !== 1'b0) begin
            n_fail++; $display("FAIL conflict_din: din=%h valid=%b expected 21 0", obs_din[3], obs_dv[3]);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  d;
        logic [15:0] a;
        for (int i = 0; i < 6; i++) begin
            d = 8'($urandom_range(0, 255));
            a = 16'hD000 + 16'(i);
            if (i == 3) begin
                run_cycle(1'b0, 1'b1, a, d, 4, 8'h00, 1'b0);
                n_assert++;
                if (obs_wdata !== d || obs_wr[2] !== 1'b1) begin
                    n_fail++; $display("FAIL b2b_write: wdata=%h wr2=%b expected %h 1", obs_wdata, obs_wr[2], d);
                end
            end else begin
                expect_read(d);
                run_cycle(1'b1, 1'b0, a, 8'h00, 1 + (i % 2), d, 1'b0);
                n_assert++;
                if (obs_addr !== a || obs_rd[1] !== 1'b1 || obs_dv[3] !== 1'b1) begin
                    n_fail++; $display("FAIL b2b_read[%0d]: addr=%h rd1=%b valid=%b expected %h 1 1", i, obs_addr, obs_rd[1], obs_dv[3], a);
                end
            end
        end
    endtask

    task automatic test_reset_mid_write();
        expect_read(8'h12);
        run_cycle(1'b1, 1'b0, 16'hC030, 8'h00, 1, 8'h12, 1'b0);
        // Reset in phase 2 while the write strobe is high.
        wait_phase0();
        bus.cpu_wr = 1'b1; bus.cpu_addr = 16'h8000; bus.cpu_dout = 8'h3C;
        @(negedge clk);
        bus.cpu_wr = 1'b0;
        @(negedge clk);
        n_assert++;
        if (bus.mem_wr !== 1'b1) begin n_fail++; $display("FAIL rst_p2_pre: mem_wr=%b expected 1", bus.mem_wr); end
        reset = 1'b1;
        @(negedge clk);
        n_assert++;
        if (bus.mem_wr !== 1'b0 || bus.phase !== T0) begin
            n_fail++; $display("FAIL rst_p2_abort: mem_wr=%b phase=%0d expected 0 0", bus.mem_wr, bus.phase);
        end
        n_assert++;
        if (bus.cpu_din !== 8'hFF || bus.mem_wdata !== 8'h00) begin
            n_fail++; $display("FAIL rst_p2_state: din=%h wdata=%h expected ff 00", bus.cpu_din, bus.mem_wdata);
        end
        reset = 1'b0;
        last_din = 8'hFF;
        // Reset in phase 1, before the strobe would rise: no partial write.
        wait_phase0();
        bus.cpu_wr = 1'b1; bus.cpu_addr = 16'h8001; bus.cpu_dout = 8'h5C;
        @(negedge clk);
        bus.cpu_wr = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        n_assert++;
        if (bus.mem_wr !== 1'b0 || bus.mem_wdata !== 8'h00) begin
            n_fail++; $display("FAIL rst_p1_no_write: mem_wr=%b wdata=%h expected 0 00", bus.mem_wr, bus.mem_wdata);
        end
        reset = 1'b0;
        drive_idle();
        run_cycle(1'b0, 1'b0, 16'h0000, 8'h00, 4, 8'h00, 1'b0);
        n_assert++;
        if ((obs_wr[1] | obs_wr[2] | obs_wr[3]) !== 1'b0 || obs_din[3] !== 8'hFF) begin
            n_fail++; $display("FAIL rst_idle_after: wr seen or din=%h, expected no write and ff", obs_din[3]);
        end
    endtask

    task automatic test_dma_lock();
`ifdef BUS_DMA_LOCK_EN
        expect_read(8'hFF);
        run_cycle(1'b1, 1'b0, 16'hC000, 8'h00, 1, 8'h42, 1'b1);
        n_assert++;
        if ((obs_rd[1] | obs_rd[2]) !== 1'b0 || obs_to[3] !== 1'b0) begin
            n_fail++; $display("FAIL lock_read_blocked: rd=%b%b to=%b expected 00 0", obs_rd[1], obs_rd[2], obs_to[3]);
        end
        expect_read(8'h11);
        run_cycle(1'b1, 1'b0, 16'hFF90, 8'h00, 1, 8'h11, 1'b1);
        n_assert++;
        if (obs_rd[1] !== 1'b1) begin n_fail++; $display("FAIL lock_hram_read: rd1=%b expected 1", obs_rd[1]); end
        expect_read(8'h80);
        run_cycle(1'b1, 1'b0, 16'hFF80, 8'h00, 2, 8'h80, 1'b1);
        expect_read(8'hFF);
        run_cycle(1'b1, 1'b0, 16'hFFFF, 8'h00, 1, 8'h33, 1'b1);
        n_assert++;
        if (obs_rd[1] !== 1'b0) begin n_fail++; $display("FAIL lock_ffff_blocked: rd1=%b expected 0", obs_rd[1]); end
        run_cycle(1'b0, 1'b1, 16'hC000, 8'h44, 4, 8'h00, 1'b1);
        n_assert++;
        if ((obs_wr[1] | obs_wr[2] | obs_wr[3]) !== 1'b0) begin n_fail++; $display("FAIL lock_write_dropped: mem_wr seen, expected none"); end
`else
        expect_read(8'h42);
        run_cycle(1'b1, 1'b0, 16'hC000, 8'h00, 1, 8'h42, 1'b1);
        n_assert++;
        if (obs_rd[1] !== 1'b1) begin n_fail++; $display("FAIL nolock_read: rd1=%b expected 1", obs_rd[1]); end
        run_cycle(1'b0, 1'b1, 16'hC000, 8'h44, 4, 8'h00, 1'b1);
        n_assert++;
        if (obs_wr[2] !== 1'b1 || obs_wdata !== 8'h44) begin
            n_fail++; $display("FAIL nolock_write: wr2=%b wdata=%h expected 1 44", obs_wr[2], obs_wdata);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_read_ack();
        test_write();
        test_read_timeout();
        test_ack_timing();
        test_conflict();
        test_back_to_back();
        test_reset_mid_write();
        test_dma_lock();
        repeat (2) @(negedge clk);
        n_assert++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL sb_leftover: %0d expected reads never delivered", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
